// File: rtl/conv_pkg.sv
// Shared conventions: default bus widths and the pipeline depth ceiling.
// No logic; constants and a small helper only.
// No flow control.
package conv_pkg;
    localparam int CONV_AW      = 32;
    localparam int CONV_DW      = 32;
    localparam int CONV_LAT_MAX = 8;

    function automatic int clamp_lat(input int lat);
        if (lat < 1)
            return 1;
        if (lat > CONV_LAT_MAX)
            return CONV_LAT_MAX;
        return lat;
    endfunction
endpackage

// File: rtl/sig_delay.sv
// Single-bit delay line of D registers, cleared by reset.
// Latency: D cycles.
// No backpressure; shifts every cycle.
module sig_delay #(
    parameter int D = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    logic [D-1:0] sr;

    if (D == 1) begin : g_one
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                sr <= '0;
            else
                sr <= din;
        end
    end else begin : g_many
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                sr <= '0;
            else
                sr <= {sr[D-2:0], din};
        end
    end

    assign dout = sr[D-1];
endmodule

// File: rtl/ext_mem_rsp.sv
// External memory responder: word array with fixed-latency pipelined reads, range check, counters.
// Latency: LAT cycles request-to-rd_valid; EXT_MEM_RSP_RAW_FWD_EN selects write-first on same-cycle hits.
// No backpressure: one read and one write accepted every cycle.
module ext_mem_rsp
    import conv_pkg::*;
#(
    parameter int AW    = CONV_AW,
    parameter int DW    = CONV_DW,
    parameter int DEPTH = 4096,
    parameter int LAT   = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_ena,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          wr_ena,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          addr_err,
    output logic [AW-1:0] rd_cnt,
    output logic [AW-1:0] wr_cnt
);
    localparam int L  = clamp_lat(LAT);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] pipe [L];
    logic [DW-1:0] rd_hold;
    logic [DW-1:0] rd_word;
    logic          rd_in;
    logic          wr_in;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] wr_idx;

    // Extra MSB keeps the compare correct when DEPTH equals 2^AW.
    assign rd_in  = {1'b0, rd_addr} < (AW+1)'(DEPTH);
    assign wr_in  = {1'b0, wr_addr} < (AW+1)'(DEPTH);
    assign rd_idx = rd_addr[IW-1:0];
    assign wr_idx = wr_addr[IW-1:0];

    always_comb begin
        rd_word = '0;
        if (rd_in)
            rd_word = mem[rd_idx];
`ifdef EXT_MEM_RSP_RAW_FWD_EN
        if (rd_in && wr_ena && (wr_addr == rd_addr))
            rd_word = wr_data;
`endif
    end

    // Array contents survive reset; only request acceptance is blocked.
    always_ff @(posedge clk) begin
        if (wr_ena && wr_in && !rst)
            mem[wr_idx] <= wr_data;
    end

    // Stage 0 captures the array at the request edge, so later writes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < L; k++)
                pipe[k] <= '0;
            rd_hold <= '0;
        end else begin
            pipe[0] <= rd_ena ? rd_word : '0;
            for (int k = 1; k < L; k++)
                pipe[k] <= pipe[k-1];
            if (rd_valid)
                rd_hold <= pipe[L-1];
        end
    end

    assign rd_data = rd_valid ? pipe[L-1] : rd_hold;

    sig_delay #(
        .D (L)
    ) u_vld_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (rd_ena),
        .dout (rd_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            addr_err <= 1'b0;
        end else begin
            if (rd_ena)
                rd_cnt <= rd_cnt + AW'(1);
            if (wr_ena)
                wr_cnt <= wr_cnt + AW'(1);
            if ((rd_ena && !rd_in) || (wr_ena && !wr_in))
                addr_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ext_mem_rsp.sv
// Randomized scoreboard bench for ext_mem_rsp, three latency builds (1, 2, 8) driven in parallel.
// Expected reads come from an array model at the request edge; a negedge monitor checks them.
module tb_ext_mem_rsp;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int NI    = 3;
`ifdef EXT_MEM_RSP_RAW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_ena;
    logic [AW-1:0] rd_addr;
    logic          wr_ena;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rd_data_v  [NI];
    logic          rd_valid_v [NI];
    logic          addr_err_v [NI];
    logic [AW-1:0] rd_cnt_v   [NI];
    logic [AW-1:0] wr_cnt_v   [NI];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit done     = 1'b0;

    exp_t          exp_log [$];
    int            head [NI];
    logic [DW-1:0] last_data [NI];
    logic [DW-1:0] ref_mem [DEPTH];
    int unsigned   m_rd  = 0;
    int unsigned   m_wr  = 0;
    bit            m_err = 1'b0;

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : (i == 1) ? 2 : 8;
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        ext_mem_rsp #(
            .AW    (AW),
            .DW    (DW),
            .DEPTH (DEPTH),
            .LAT   ((g == 0) ? 1 : (g == 1) ? 2 : 8)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .rd_ena   (rd_ena),
            .rd_addr  (rd_addr),
            .rd_data  (rd_data_v[g]),
            .rd_valid (rd_valid_v[g]),
            .wr_ena   (wr_ena),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .addr_err (addr_err_v[g]),
            .rd_cnt   (rd_cnt_v[g]),
            .wr_cnt   (wr_cnt_v[g])
        );
    end

    // Reference model: sample the request at the edge it is accepted.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_rd  = 0;
            m_wr  = 0;
            m_err = 1'b0;
        end else begin
            if (rd_ena) begin
                exp_t e;
                e.cyc = cyc;
                if (int'(rd_addr) >= DEPTH)
                    e.data = '0;
                else if (FWD && wr_ena && wr_addr == rd_addr)
                    e.data = wr_data;
                else
                    e.data = ref_mem[int'(rd_addr)];
                exp_log.push_back(e);
                m_rd++;
                if (int'(rd_addr) >= DEPTH)
                    m_err = 1'b1;
            end
            if (wr_ena) begin
                m_wr++;
                if (int'(wr_addr) < DEPTH)
                    ref_mem[int'(wr_addr)] = wr_data;
                else
                    m_err = 1'b1;
            end
        end
    end

    task automatic chk(input string nm, input int i, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s inst=%0d lat=%0d cyc=%0d got=%0h want=%0h", nm, i, lat_of(i), cyc, got, want);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (rst) begin
                head[i] = exp_log.size();
                chk("rst_valid", i, 64'(rd_valid_v[i]), 64'd0);
                chk("rst_data", i, 64'(rd_data_v[i]), 64'd0);
                last_data[i] = '0;
            end else if (rd_valid_v[i] === 1'b1) begin
                if (head[i] >= exp_log.size()) begin
                    chk("unexpected_valid", i, 64'd1, 64'd0);
                end else begin
                    chk("rd_data", i, 64'(rd_data_v[i]), 64'(exp_log[head[i]].data));
                    chk("rd_latency", i, 64'(cyc - exp_log[head[i]].cyc), 64'(lat_of(i)));
                    head[i]++;
                end
                last_data[i] = rd_data_v[i];
            end else begin
                chk("rd_valid_low", i, 64'(rd_valid_v[i]), 64'd0);
                chk("rd_data_hold", i, 64'(rd_data_v[i]), 64'(last_data[i]));
            end
            chk("rd_cnt", i, 64'(rd_cnt_v[i]), 64'(m_rd % (1 << AW)));
            chk("wr_cnt", i, 64'(wr_cnt_v[i]), 64'(m_wr % (1 << AW)));
            chk("addr_err", i, 64'(addr_err_v[i]), 64'(m_err));
        end
        if (done) begin
            for (int i = 0; i < NI; i++)
                chk("drain", i, 64'(head[i]), 64'(exp_log.size()));
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    task automatic drive(input bit re, input int ra, input bit we, input int wa, input logic [DW-1:0] wd);
        @(negedge clk);
        #1;
        rd_ena  = re;
        rd_addr = AW'(ra);
        wr_ena  = we;
        wr_addr = AW'(wa);
        wr_data = wd;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            drive(1'b0, 0, 1'b0, 0, '0);
    endtask

    // Enables stay high during reset with a junk write to addr 3: all must be ignored.
    task automatic do_reset();
        @(negedge clk);
        #2;
        rst     = 1'b1;
        rd_ena  = 1'b1;
        rd_addr = AW'(3);
        wr_ena  = 1'b1;
        wr_addr = AW'(3);
        wr_data = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        #2;
        rst    = 1'b0;
        rd_ena = 1'b0;
        wr_ena = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        rd_ena  = 1'b0;
        rd_addr = '0;
        wr_ena  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b0;

        for (int a = 0; a < DEPTH; a++)
            drive(1'b0, 0, 1'b1, a, $urandom);
        do_reset();
        drive(1'b1, 3, 1'b0, 0, '0);

        drive(1'b0, 0, 1'b1, 5, 32'hA5A5_0001);
        idle(1);
        drive(1'b1, 5, 1'b0, 0, '0);
        idle(10);

        do_reset();
        for (int a = 0; a < 8; a++)
            drive(1'b1, a, 1'b0, 0, '0);
        idle(10);

        drive(1'b0, 0, 1'b1, 9, 32'h11);
        drive(1'b1, 9, 1'b1, 9, 32'h22);
        drive(1'b1, 9, 1'b0, 0, '0);
        idle(10);

        drive(1'b1, DEPTH, 1'b0, 0, '0);
        drive(1'b0, 0, 1'b1, DEPTH + 3, 32'h5A5A_5A5A);
        drive(1'b1, 3, 1'b0, 0, '0);
        idle(10);

        drive(1'b1, 10, 1'b0, 0, '0);
        do_reset();
        idle(2);
        drive(1'b1, 10, 1'b0, 0, '0);
        idle(10);

        for (int n = 0; n < 400; n++) begin
            int ra;
            int wa;
            ra = $urandom_range(0, DEPTH + 15);
            wa = ($urandom_range(0, 3) == 0) ? ra : $urandom_range(0, DEPTH + 15);
            drive($urandom_range(0, 3) != 0, ra, $urandom_range(0, 1) == 1, wa, $urandom);
        end
        idle(12);
        done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1);
    end
endmodule
